flappy_game_ctrl: RTL and testbench

//  Game-flow sequencer for the pipe scroller (X coordinate store + score counter).

---
 rtl/flappy_game_ctrl_pkg.sv | 30 +++
 rtl/flappy_game_ctrl_scroll_burst_gen.sv | 28 ++
 rtl/flappy_game_ctrl.sv | 134 +++++++++++++
 tb/tb_flappy_game_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/flappy_game_ctrl_pkg.sv
// Shared definitions for the flappy game-flow controller and its display consumers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package flappy_game_ctrl_pkg;

   // State codes are also decoded by the VGA/score display, so keep them fixed.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_PLAY  = 3'd2,
      ST_DYING = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   localparam int READY_FRAMES_DEF = 60;
   localparam int DEATH_FRAMES_DEF = 90;
   localparam int SPEED_DIV_DEF    = 4;
   localparam int MAX_SPEED_DEF    = 4;

   // Scroll speed in px/frame: one extra pixel every speed_div points, capped.
   function automatic logic [2:0] speed_calc(input logic [3:0] score,
                                             input int         speed_div,
                                             input int         max_speed);
      int s;
      s = 1 + int'({28'd0, score}) / speed_div;
      if (s > max_speed) s = max_speed;
      return s[2:0];
   endfunction

endpackage

// File: rtl/flappy_game_ctrl_scroll_burst_gen.sv
// Emits len consecutive count_en pulses after a load, one per pixel of scroll.
// Latency: first pulse the cycle after load; abort kills count_en in the same cycle.
// Backpressure: none; a load while busy is the caller's job to suppress.
module scroll_burst_gen (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [2:0] len,
   input  logic       abort,
   output logic       count_en,
   output logic       busy
);

   logic [2:0] remain;

   // Down-counter of pixels still to scroll in this frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                remain <= 3'd0;
      else if (abort)           remain <= 3'd0;
      else if (load)            remain <= len;
      else if (remain != 3'd0)  remain <= remain - 3'd1;
   end

   // Abort masks the pulse combinationally so a collision stops the pipes at once.
   assign busy     = (remain != 3'd0);
   assign count_en = busy & ~abort;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game-flow sequencer: IDLE -> READY countdown -> PLAY scrolling -> DYING freeze -> OVER.
// Latency: state changes one cycle after the triggering btn edge / frame_tick / lose.
// Backpressure: none; frame_ticks arriving mid-burst are dropped.
module flappy_game_ctrl
   import flappy_game_ctrl_pkg::*;
#(
   parameter int READY_FRAMES = READY_FRAMES_DEF,
   parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
   parameter int SPEED_DIV    = SPEED_DIV_DEF,
   parameter int MAX_SPEED    = MAX_SPEED_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn,
   input  logic       lose,
   input  logic [3:0] score,
   output logic       pipe_reset,
   output logic       count_en,
   output logic       bird_en,
   output logic [2:0] state,
   output logic       game_over,
   output logic [3:0] hi_score
);

   localparam int FC_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
   localparam int FC_W   = $clog2(FC_MAX + 1);

   state_t            state_q, state_nxt;
   logic              btn_q;
   logic              btn_rise;
   logic [FC_W-1:0]   frame_cnt;
   logic              fc_load_ready, fc_load_death, fc_dec;
   logic              hi_upd;
   logic              burst_load, burst_abort, burst_busy;
   logic              last_frame;

   assign btn_rise   = btn & ~btn_q;
   assign last_frame = (frame_cnt <= FC_W'(1));
   assign state      = state_q;

   // Button history for rising-edge detection; a held button never retriggers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) btn_q <= 1'b0;
      else        btn_q <= btn;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_nxt;
   end

   // Next-state and output decode.
   always_comb begin
      state_nxt     = state_q;
      pipe_reset    = 1'b0;
      bird_en       = 1'b0;
      game_over     = 1'b0;
      burst_load    = 1'b0;
      burst_abort   = 1'b0;
      fc_load_ready = 1'b0;
      fc_load_death = 1'b0;
      fc_dec        = 1'b0;
      hi_upd        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pipe_reset = 1'b1;
            if (btn_rise) begin
               state_nxt     = ST_READY;
               fc_load_ready = 1'b1;
            end
         end
         ST_READY: begin
            bird_en = 1'b1;
            if (frame_tick) begin
               fc_dec = 1'b1;
               if (last_frame) state_nxt = ST_PLAY;
            end
         end
         ST_PLAY: begin
            bird_en = 1'b1;
            if (lose) begin
               // Collision wins over a coincident frame_tick: no new burst.
               burst_abort   = 1'b1;
               fc_load_death = 1'b1;
               hi_upd        = 1'b1;
               state_nxt     = ST_DYING;
            end else if (frame_tick && !burst_busy) begin
               burst_load = 1'b1;
            end
         end
         ST_DYING: begin
            if (frame_tick) begin
               fc_dec = 1'b1;
               if (last_frame) state_nxt = ST_OVER;
            end
         end
         ST_OVER: begin
            game_over = 1'b1;
            if (btn_rise) state_nxt = ST_IDLE;
         end
         default: begin
            pipe_reset = 1'b1;
            state_nxt  = ST_IDLE;
         end
      endcase
   end

   // Shared frame counter for the READY countdown and the DYING freeze.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           frame_cnt <= '0;
      else if (fc_load_ready)              frame_cnt <= FC_W'(READY_FRAMES);
      else if (fc_load_death)              frame_cnt <= FC_W'(DEATH_FRAMES);
      else if (fc_dec && frame_cnt != '0)  frame_cnt <= frame_cnt - FC_W'(1);
   end

   // Best score, captured on the PLAY->DYING transition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          hi_score <= 4'd0;
      else if (hi_upd && score > hi_score) hi_score <= score;
   end

   scroll_burst_gen u_burst (
      .clk      (clk),
      .reset    (reset),
      .load     (burst_load),
      .len      (speed_calc(score, SPEED_DIV, MAX_SPEED)),
      .abort    (burst_abort),
      .count_en (count_en),
      .busy     (burst_busy)
   );

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: reset, countdown, speed bursts, collision, restart, async reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_flappy_game_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       btn;
   logic       lose;
   logic [3:0] score;
   logic       pipe_reset;
   logic       count_en;
   logic       bird_en;
   logic [2:0] state;
   logic       game_over;
   logic [3:0] hi_score;

   int tests  = 0;
   int failed = 0;
   int en_total = 0;
   int snap;

   flappy_game_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .btn        (btn),
      .lose       (lose),
      .score      (score),
      .pipe_reset (pipe_reset),
      .count_en   (count_en),
      .bird_en    (bird_en),
      .state      (state),
      .game_over  (game_over),
      .hi_score   (hi_score)
   );

   always #5 clk = ~clk;

   // Running total of scroll pulses, sampled mid-cycle.
   always @(negedge clk) if (count_en === 1'b1) en_total = en_total + 1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         failed = failed + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One 16-cycle video frame starting with a frame_tick pulse.
   task automatic frame();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (15) step();
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; btn = 1'b0; lose = 1'b0; score = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_pipe_reset", 8'(pipe_reset), 8'd1);
      chk("rst_count_en", 8'(count_en), 8'd0);
      chk("rst_bird_en", 8'(bird_en), 8'd0);
      chk("rst_game_over", 8'(game_over), 8'd0);
      chk("rst_hi_score", 8'(hi_score), 8'd0);
      reset = 1'b0;

      // Idle for three frames.
      snap = en_total;
      repeat (3) frame();
      chk("idle_en_pulses", 8'(en_total - snap), 8'd0);
      chk("idle_state", 8'(state), 8'd0);
      chk("idle_pipe_reset", 8'(pipe_reset), 8'd1);

      // Start press; held for a while to show it does not retrigger.
      btn = 1'b1;
      step();
      chk("start_state", 8'(state), 8'd1);
      chk("ready_pipe_reset", 8'(pipe_reset), 8'd0);
      chk("ready_bird_en", 8'(bird_en), 8'd1);
      snap = en_total;
      repeat (59) frame();
      btn = 1'b0;
      chk("ready_after_59", 8'(state), 8'd1);
      chk("ready_no_scroll", 8'(en_total - snap), 8'd0);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("play_after_60", 8'(state), 8'd2);
      repeat (15) step();

      // 61st tick: first scroll pulse one cycle after the tick, score 0 -> 1 px.
      snap = en_total;
      frame_tick = 1'b1;
      @(negedge clk);
      chk("tick_cycle_en", 8'(count_en), 8'd0);
      step();
      frame_tick = 1'b0;
      @(negedge clk);
      chk("first_scroll_en", 8'(count_en), 8'd1);
      repeat (15) step();
      chk("burst_score0", 8'(en_total - snap), 8'd1);

      score = 4'd3;  snap = en_total; frame(); chk("burst_score3", 8'(en_total - snap), 8'd1);
      score = 4'd4;  snap = en_total; frame(); chk("burst_score4", 8'(en_total - snap), 8'd2);
      score = 4'd9;  snap = en_total; frame(); chk("burst_score9", 8'(en_total - snap), 8'd3);
      score = 4'd15; snap = en_total; frame(); chk("burst_score15", 8'(en_total - snap), 8'd4);

      // Second tick during an active burst is dropped.
      snap = en_total;
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
      frame_tick = 1'b1; step();
      frame_tick = 1'b0;
      repeat (13) step();
      chk("tick_dropped", 8'(en_total - snap), 8'd4);

      // Score is sampled only in the tick cycle.
      score = 4'd4; snap = en_total;
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; score = 4'd15;
      repeat (15) step();
      chk("score_sampled", 8'(en_total - snap), 8'd2);

      // Collision on the 2nd cycle of a 3-pulse burst.
      score = 4'd9; snap = en_total;
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
      lose = 1'b1;
      @(negedge clk);
      chk("abort_same_cycle", 8'(count_en), 8'd0);
      step();
      lose = 1'b0;
      chk("dying_state", 8'(state), 8'd3);
      chk("dying_hi_score", 8'(hi_score), 8'd9);
      chk("dying_bird_en", 8'(bird_en), 8'd0);
      repeat (5) step();
      chk("abort_pulses", 8'(en_total - snap), 8'd1);

      // Button ignored while dying.
      btn = 1'b1; step(); btn = 1'b0; step();
      chk("dying_btn_ignored", 8'(state), 8'd3);

      repeat (89) frame();
      chk("dying_after_89", 8'(state), 8'd3);
      btn = 1'b1;
      frame_tick = 1'b1; step();
      frame_tick = 1'b0;
      chk("over_state", 8'(state), 8'd4);
      chk("over_game_over", 8'(game_over), 8'd1);
      repeat (5) step();
      chk("over_held_btn", 8'(state), 8'd4);
      btn = 1'b0; step(); step();
      chk("over_released", 8'(state), 8'd4);
      btn = 1'b1; step();
      chk("restart_state", 8'(state), 8'd0);
      chk("restart_pipe_reset", 8'(pipe_reset), 8'd1);
      chk("restart_game_over", 8'(game_over), 8'd0);
      chk("hi_kept", 8'(hi_score), 8'd9);
      btn = 1'b0; step();

      // Second game up to a burst, then async reset between edges.
      btn = 1'b1; step(); btn = 1'b0;
      chk("game2_ready", 8'(state), 8'd1);
      repeat (60) frame();
      chk("game2_play", 8'(state), 8'd2);
      score = 4'd15;
      frame_tick = 1'b1; step();
      frame_tick = 1'b0;
      @(negedge clk);
      chk("game2_burst_on", 8'(count_en), 8'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_count_en", 8'(count_en), 8'd0);
      chk("arst_state", 8'(state), 8'd0);
      chk("arst_pipe_reset", 8'(pipe_reset), 8'd1);
      chk("arst_bird_en", 8'(bird_en), 8'd0);
      chk("arst_hi_score", 8'(hi_score), 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      snap = en_total;
      repeat (16) step();
      chk("post_rst_no_glitch", 8'(en_total - snap), 8'd0);
      chk("post_rst_state", 8'(state), 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
